// File: rtl/audio_pkg.sv
// Shared definitions for the codec record-path deserializer.
`timescale 1ns/1ps
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A sampled level that is now high but was low one observation earlier.
  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous single-bit input.
`timescale 1ns/1ps
module sync2 (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter: two back-to-back flops into the clk_i domain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial2para.sv
// DSP-mode codec record stream to parallel left/right samples, clocked on clk96M.
`timescale 1ns/1ps
module serial2para
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk96M,
  input  logic                reset,
  input  logic                bclk,
  input  logic                reclrc,
  input  logic                recdat,
  output logic [SAMPLE_W-1:0] left,
  output logic [SAMPLE_W-1:0] right,
  output logic                valid,
  output logic                frame_err
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int CNT_W   = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  logic bclk_s;
  logic lrc_s;
  logic dat_s;
  logic bit_tick_s;
  logic frame_start_s;

  logic                bclk_prev_q, bclk_prev_d;
  logic                lrc_prev_q,  lrc_prev_d;
  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [FRAME_W-1:0]  shreg_q,     shreg_d;
  logic [SAMPLE_W-1:0] left_q,      left_d;
  logic [SAMPLE_W-1:0] right_q,     right_d;
  logic                valid_q,     valid_d;
  logic                frame_err_q, frame_err_d;

  sync2 u_sync_bclk (.clk_i(clk96M), .reset_i(reset), .d_i(bclk),   .q_o(bclk_s));
  sync2 u_sync_lrc  (.clk_i(clk96M), .reset_i(reset), .d_i(reclrc), .q_o(lrc_s));
  sync2 u_sync_dat  (.clk_i(clk96M), .reset_i(reset), .d_i(recdat), .q_o(dat_s));

  // reclrc history advances only on bit ticks, so a level held for several
  // bclk periods yields exactly one frame start.
  assign bit_tick_s    = rise_edge(bclk_s, bclk_prev_q);
  assign frame_start_s = bit_tick_s & rise_edge(lrc_s, lrc_prev_q);

  // Next-state logic for edge history, frame FSM, shift register and outputs.
  always_comb begin
    bclk_prev_d = bclk_s;
    lrc_prev_d  = lrc_prev_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    if (bit_tick_s) begin
      lrc_prev_d = lrc_s;
    end else begin
      lrc_prev_d = lrc_prev_q;
    end

    case (state_q)
      IDLE: begin
        if (frame_start_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (frame_start_s) begin
          // Aborted frame: the partial word is dropped and capture restarts.
          frame_err_d = 1'b1;
          state_d     = SHIFT;
          cnt_d       = '0;
          shreg_d     = '0;
        end else if (bit_tick_s) begin
          shreg_d = {shreg_q[FRAME_W-2:0], dat_s};
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end

      DONE: begin
        left_d  = shreg_q[FRAME_W-1:SAMPLE_W];
        right_d = shreg_q[SAMPLE_W-1:0];
        valid_d = 1'b1;
        if (frame_start_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  // Single state register for the whole block; outputs are registered.
  always_ff @(posedge clk96M) begin
    if (reset) begin
      bclk_prev_q <= 1'b0;
      lrc_prev_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bclk_prev_q <= bclk_prev_d;
      lrc_prev_q  <= lrc_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;

endmodule
